// File: rtl/xorshift_burst_gen.sv
// rtl/xorshift_burst_gen.sv - xorshift pseudo-random burst generator feeding a FIFO write port
//
// Purpose: on an accepted seed, emits NUM_OUT xorshift words (mode 0) or an
// unbounded stream (mode 1), stalling on fifo_full and ending early on stop.
//
// Ports:
//   clk        in   single clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   seed strobe, accepted only in IDLE
//   seed       in   seed value, sampled with in_valid
//   mode       in   0 = burst of NUM_OUT words, 1 = continuous
//   stop       in   ends a run early, RUN only
//   fifo_full  in   write-side backpressure
//   out_valid  out  rand_num is written this cycle
//   rand_num   out  current random word
//   out_cnt    out  index of the current word within the run
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse when a run ends
//
// Configuration macro: XS_ZERO_SEED_GUARD_EN - replace a zero seed by SEED_DEFAULT.

module xorshift_burst_gen #(
    parameter int               WIDTH        = 32,
    parameter int               SHIFT_A      = 13,
    parameter int               SHIFT_B      = 17,
    parameter int               SHIFT_C      = 5,
    parameter int               NUM_OUT      = 256,
    parameter int               CNT_W        = $clog2(NUM_OUT),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    input  logic             stop,
    input  logic             fifo_full,
    output logic             out_valid,
    output logic [WIDTH-1:0] rand_num,
    output logic [CNT_W-1:0] out_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUT - 1);

`ifdef XS_ZERO_SEED_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] seed_eff;

    function automatic logic [WIDTH-1:0] xs(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = x ^ (x << SHIFT_A);
        b = a ^ (a >> SHIFT_B);
        return b ^ (b << SHIFT_C);
    endfunction

    // Zero is the xorshift fixed point; the guard swaps it for a usable seed.
    assign seed_eff = (GUARD_EN && (seed == '0)) ? SEED_DEFAULT : seed;

    // A transfer needs both a free FIFO and no stop; stop takes priority.
    assign out_valid = (state_q == ST_RUN) && !fifo_full && !stop;
    assign rand_num  = x_q;
    assign out_cnt   = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    x_d     = xs(seed_eff);
                    cnt_d   = '0;
                    mode_d  = mode;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (!fifo_full) begin
                    x_d   = xs(x_q);
                    // Wraps naturally in continuous mode.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!mode_q && (cnt_q == LAST_IDX)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_xorshift_burst_gen.sv
// tb/tb_xorshift_burst_gen.sv - self-checking bench for xorshift_burst_gen
module tb_xorshift_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        mode = 1'b0;
    logic        stop = 1'b0;
    logic        fifo_full = 1'b0;
    logic        out_valid;
    logic [31:0] rand_num;
    logic [7:0]  out_cnt;
    logic        busy;
    logic        done;

    logic        in_valid64 = 1'b0;
    logic [63:0] seed64 = '0;
    logic        mode64 = 1'b0;
    logic        stop64 = 1'b0;
    logic        fifo_full64 = 1'b0;
    logic        out_valid64;
    logic [63:0] rand_num64;
    logic [7:0]  out_cnt64;
    logic        busy64;
    logic        done64;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_x;
    int          m_idx = 0;
    logic [63:0] m_x64;
    int          m_idx64 = 0;

    always #5 clk = ~clk;

    xorshift_burst_gen #(.WIDTH(32), .SHIFT_A(13), .SHIFT_B(17), .SHIFT_C(5), .NUM_OUT(256)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .seed(seed), .mode(mode),
        .stop(stop), .fifo_full(fifo_full), .out_valid(out_valid), .rand_num(rand_num),
        .out_cnt(out_cnt), .busy(busy), .done(done)
    );

    xorshift_burst_gen #(.WIDTH(64), .SHIFT_A(13), .SHIFT_B(7), .SHIFT_C(17), .NUM_OUT(256)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .seed(seed64), .mode(mode64),
        .stop(stop64), .fifo_full(fifo_full64), .out_valid(out_valid64), .rand_num(rand_num64),
        .out_cnt(out_cnt64), .busy(busy64), .done(done64)
    );

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    function automatic logic [31:0] seed_eff(input logic [31:0] s);
`ifdef XS_ZERO_SEED_GUARD_EN
        return (s == 32'd0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Compare process: every transfer must carry the next model word and index.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("data32", {32'd0, rand_num}, {32'd0, m_x});
                chk("cnt32", {56'd0, out_cnt}, 64'(m_idx % 256));
                m_x = xs32(m_x);
                m_idx++;
            end
            chk("valid_done_excl32", {63'd0, out_valid && done}, 64'd0);
            chk("done_implies_busy32", {63'd0, done && !busy}, 64'd0);
            if (out_valid64) begin
                chk("data64", rand_num64, m_x64);
                chk("cnt64", {56'd0, out_cnt64}, 64'(m_idx64 % 256));
                m_x64 = xs64(m_x64);
                m_idx64++;
            end
            chk("valid_done_excl64", {63'd0, out_valid64 && done64}, 64'd0);
        end
    end

    task automatic start(input logic [31:0] s, input logic md);
        @(posedge clk); #1;
        in_valid = 1'b1;
        seed     = s;
        mode     = md;
        m_x      = xs32(seed_eff(s));
        m_idx    = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // k counts cycles after acceptance: k = 1 is the cycle T+1.
    task automatic run(input int stall_k, input int stall_len, input int stop_k, input int ign_k,
                       output int nvalid, output int done_k, output int idle_k,
                       output logic [31:0] w0, output logic [31:0] w1);
        int  ndone;
        bit  stalled;
        nvalid = 0; done_k = -1; idle_k = -1; ndone = 0; w0 = '0; w1 = '0;
        for (int k = 1; k <= 2000 && idle_k < 0; k++) begin
            stalled   = (k >= stall_k) && (k < stall_k + stall_len);
            fifo_full = stalled || (k == stop_k);
            stop      = (k == stop_k);
            in_valid  = (k == ign_k);
            if (k == ign_k) seed = 32'hDEADBEEF;
            @(negedge clk);
            if (k == 1) begin
                w0 = rand_num;
                chk("latency_first_valid", {63'd0, out_valid}, 64'd1);
            end
            if (k == 2) w1 = rand_num;
            if (stalled) begin
                chk("stall_no_valid", {63'd0, out_valid}, 64'd0);
                chk("stall_hold_data", {32'd0, rand_num}, {32'd0, m_x});
                chk("stall_hold_cnt", {56'd0, out_cnt}, 64'(m_idx % 256));
            end
            if (k == stop_k) chk("stop_no_valid", {63'd0, out_valid}, 64'd0);
            if (out_valid && nvalid == 255) chk("cnt_at_255", {56'd0, out_cnt}, 64'd255);
            if (out_valid && nvalid == 256) chk("cnt_wrap_256", {56'd0, out_cnt}, 64'd0);
            if (out_valid) nvalid++;
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (!busy && done_k >= 0 && idle_k < 0) idle_k = k;
            @(posedge clk); #1;
        end
        fifo_full = 1'b0; stop = 1'b0; in_valid = 1'b0;
        chk("single_done_pulse", 64'(ndone), 64'd1);
        if (idle_k < 0) chk("run_timeout", 64'd0, 64'd1);
    endtask

    int nv, dk, ik;
    logic [31:0] w0, w1;

    initial begin
        // Reset state.
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_rand_num", {32'd0, rand_num}, 64'd0);
        chk("rst_out_cnt", {56'd0, out_cnt}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_done", {63'd0, done}, 64'd0);

        // Basic burst, seed 1.
        start(32'd1, 1'b0);
        run(0, 0, -1, -1, nv, dk, ik, w0, w1);
        chk("basic_first_word", {32'd0, w0}, 64'h0004_2021);
        chk("basic_second_word", {32'd0, w1}, 64'h0408_0601);
        chk("basic_nvalid", 64'(nv), 64'd256);
        chk("basic_done_k", 64'(dk), 64'd257);
        chk("basic_idle_k", 64'(ik), 64'd258);

        // Backpressure: 3 stall cycles on word 10 (cycle k = 11).
        start(32'd1, 1'b0);
        run(11, 3, -1, -1, nv, dk, ik, w0, w1);
        chk("stall_nvalid", 64'(nv), 64'd256);
        chk("stall_done_k", 64'(dk), 64'd260);
        chk("stall_idle_k", 64'(ik), 64'd261);

        // Continuous mode, stop (with fifo_full) after 300 transfers.
        start(32'h0000_BEEF, 1'b1);
        run(0, 0, 301, -1, nv, dk, ik, w0, w1);
        chk("stop_nvalid", 64'(nv), 64'd300);
        chk("stop_done_k", 64'(dk), 64'd302);
        chk("stop_idle_k", 64'(ik), 64'd303);

        // Seed strobe mid-burst is ignored.
        start(32'd1, 1'b0);
        run(0, 0, -1, 50, nv, dk, ik, w0, w1);
        chk("ign_nvalid", 64'(nv), 64'd256);
        chk("ign_done_k", 64'(dk), 64'd257);

        // A fresh seed afterwards is accepted normally.
        start(32'h0000_1234, 1'b0);
        run(0, 0, -1, -1, nv, dk, ik, w0, w1);
        chk("fresh_first_word", {32'd0, w0}, {32'd0, xs32(32'h0000_1234)});
        chk("fresh_nvalid", 64'(nv), 64'd256);

        // Reset mid-burst clears everything at once.
        start(32'd1, 1'b0);
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_rand_num", {32'd0, rand_num}, 64'd0);
        chk("midrst_out_cnt", {56'd0, out_cnt}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero seed.
        start(32'd0, 1'b0);
        run(0, 0, -1, -1, nv, dk, ik, w0, w1);
`ifdef XS_ZERO_SEED_GUARD_EN
        chk("zero_seed_first", {32'd0, w0}, 64'h0004_2021);
`else
        chk("zero_seed_first", {32'd0, w0}, 64'd0);
`endif
        chk("zero_seed_nvalid", 64'(nv), 64'd256);
        chk("zero_seed_done_k", 64'(dk), 64'd257);

        // 64-bit instance, shifts 13/7/17, seed 1.
        @(posedge clk); #1;
        in_valid64 = 1'b1;
        seed64     = 64'd1;
        mode64     = 1'b0;
        m_x64      = xs64(64'd1);
        m_idx64    = 0;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        nv = 0; dk = -1;
        for (int k = 1; k <= 400 && dk < 0; k++) begin
            @(negedge clk);
            if (k == 1) chk("w64_first_word", rand_num64, 64'h0000_0000_4082_2041);
            if (out_valid64) nv++;
            if (done64) dk = k;
            @(posedge clk); #1;
        end
        chk("w64_nvalid", 64'(nv), 64'd256);
        chk("w64_done_k", 64'(dk), 64'd257);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xorshift_burst_gen.md
# xorshift_burst_gen

Parametrised xorshift pseudo-random burst generator for the clk2 domain, sitting between the seed handshake synchroniser and the asynchronous FIFO write port. On a seed it produces a burst of NUM_OUT numbers, or an unbounded stream in continuous mode, and stalls on FIFO backpressure. It generalises the fixed 32-bit, 256-word generator with configurable word width, shift triple, burst length, a stop request, a completion pulse and an output index.

## Interface
- WIDTH, 32: data width; 32 or 64.
- SHIFT_A, 13: first left-shift amount.
- SHIFT_B, 17: right-shift amount.
- SHIFT_C, 5: second left-shift amount.
- NUM_OUT, 256: burst length in mode 0; at least 2.
- CNT_W, $clog2(NUM_OUT): index width.
- SEED_DEFAULT, 1: substitute seed; used only under the configuration macro.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  seed strobe; accepted only in IDLE.
- seed  in  WIDTH  seed value, sampled with in_valid.
- mode  in  1  sampled with in_valid; 0 = burst, 1 = continuous.
- stop  in  1  ends a run early; ignored outside RUN.
- fifo_full  in  1  backpressure from the FIFO write side.
- out_valid  out  1  rand_num is written this cycle.
- rand_num  out  WIDTH  current random word.
- out_cnt  out  CNT_W  index of the current word within the run.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse when a run ends.

## Operation
- Step function xs(x):
  - a = x ^ (x << SHIFT_A)
  - b = a ^ (a >> SHIFT_B)
  - xs = b ^ (b << SHIFT_C)
  - All shifts are logical and truncated to WIDTH.
- States:
  - IDLE -> RUN on in_valid. Load the state register with xs(seed), clear out_cnt, latch mode.
  - RUN: out_valid = !fifo_full && !stop, combinational. rand_num is the state register.
  - RUN, on each transfer: state <= xs(state); out_cnt <= out_cnt + 1.
  - RUN -> DONE in mode 0, on the transfer with out_cnt == NUM_OUT-1.
  - RUN -> DONE in any mode when stop = 1. That cycle has no transfer.
  - DONE: done = 1, out_valid = 0. Next cycle -> IDLE.
- fifo_full = 1 in RUN: no transfer. State, rand_num and out_cnt hold.
- Continuous mode: out_cnt wraps modulo 2^CNT_W. There is no automatic end.
- in_valid while busy is ignored. The seed is dropped and no state changes.
- stop and fifo_full in the same cycle: stop wins, go to DONE.
- In IDLE and DONE the state register holds the last value, so rand_num holds that value.
- Reset mid-run: all registers clear immediately and the in-flight burst is abandoned.

## Timing
- Reset values:
  - out_valid 0, rand_num 0, out_cnt 0, busy 0, done 0.
  - State IDLE, latched mode 0.
- Latency: in_valid at cycle T, first out_valid at T+1 if fifo_full = 0.
- Throughput: one word per cycle while fifo_full = 0.
- Burst of NUM_OUT with no stalls:
  - out_valid high for cycles T+1 .. T+NUM_OUT.
  - done at T+NUM_OUT+1.
  - busy low from T+NUM_OUT+2.
- A new in_valid is accepted no earlier than T+NUM_OUT+2.
- Each fifo_full cycle in RUN adds exactly one cycle to the burst.
- out_valid and done are mutually exclusive. done is never asserted in IDLE.

## Configuration
- XS_ZERO_SEED_GUARD_EN defined: a seed of 0 at acceptance is replaced by SEED_DEFAULT before xs is applied.
- Without it: seed 0 produces an all-zero stream, which is the xorshift fixed point. Burst length and timing are identical either way.

## Test plan
- Basic burst: WIDTH=32, seed=1, mode=0, fifo_full=0.
  - First rand_num = 0x00042021, out_cnt = 0 at T+1.
  - Exactly 256 out_valid cycles, then a single done pulse.
  - Stream matches the software xorshift32 model.
- Backpressure: assert fifo_full for 3 cycles at word 10.
  - rand_num and out_cnt hold at word 10; no out_valid during the stall.
  - Burst completes with 256 transfers, done 3 cycles later than the unstalled run.
- Stop: mode=1, assert stop after 300 transfers.
  - out_cnt wraps 255 -> 0 at transfer 256.
  - out_valid = 0 in the stop cycle; done the next cycle; busy low one cycle after that.
- Ignored seed: in_valid with seed=0xDEADBEEF mid-burst.
  - Output stream and count are unaffected.
  - After return to IDLE, a fresh seed is accepted normally.
- Reset and zero seed:
  - rst_n low mid-burst: all outputs 0 in the same cycle.
  - seed=0 with the macro: stream equals the seed=1 stream.
  - seed=0 without the macro: 256 zero words.
- WIDTH=64, shifts 13/7/17, seed=1: output matches the software xorshift64 model for all NUM_OUT words.
